// File: rtl/ppu_mem_arbiter.sv
// Shares the VRAM and OAM ports between CPU, PPU fetchers and OAM DMA,
// applying the LCD-mode lockout rules and running the $FF46 DMA engine.
module ppu_mem_arbiter #(
    parameter int DMA_LEN         = 160,
    parameter int TICKS_PER_BYTE  = 4,
    parameter int DMA_START_DELAY = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tick_in,
    input  logic        lcd_en_in,
    input  logic [1:0]  ppu_mode_in,
    input  logic        cpu_req_in,
    input  logic [15:0] cpu_addr_in,
    input  logic        cpu_we_in,
    input  logic [7:0]  cpu_wdata_in,
    output logic [7:0]  cpu_rdata_out,
    output logic        cpu_ack_out,
    input  logic        ppu_vram_req_in,
    input  logic [12:0] ppu_vram_addr_in,
    output logic [7:0]  ppu_vram_data_out,
    output logic        ppu_vram_valid_out,
    input  logic        ppu_oam_req_in,
    input  logic [7:0]  ppu_oam_addr_in,
    output logic [7:0]  ppu_oam_data_out,
    output logic        ppu_oam_valid_out,
    output logic [12:0] vram_addr_out,
    output logic        vram_we_out,
    output logic [7:0]  vram_wdata_out,
    input  logic [7:0]  vram_rdata_in,
    output logic [7:0]  oam_addr_out,
    output logic        oam_we_out,
    output logic [7:0]  oam_wdata_out,
    input  logic [7:0]  oam_rdata_in,
    output logic        dma_src_req_out,
    output logic [15:0] dma_src_addr_out,
    input  logic [7:0]  dma_src_data_in,
    input  logic        dma_src_valid_in,
    output logic        dma_active_out
);

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_XFER
    } dma_state_t;

    typedef enum logic [2:0] {
        RSP_NONE,
        RSP_VRAM,
        RSP_OAM,
        RSP_FF,
        RSP_ZERO,
        RSP_REG
    } rsp_t;

    localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
    localparam logic [7:0] START_LAST = 8'(DMA_START_DELAY - 1);
    localparam logic [7:0] BYTE_LAST  = 8'(TICKS_PER_BYTE - 1);

    dma_state_t state_q, state_d;
    rsp_t       rsp_q, rsp_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic       pend_q, pend_d;
    logic       req_q, req_d;
    logic       pvv_q, pov_q;

    logic act;
    logic cpu_vram_hit, cpu_oam_hit, cpu_void_hit, cpu_dma_hit;
    logic ppu_owns_vram, ppu_owns_oam, cpu_owns_oam;
    logic dma_restart, dma_wr;
    logic ppu_vram_go, ppu_oam_go, cpu_vram_go, cpu_oam_go;

    // Combinational port drives are gated so every output reads 0 in reset
    assign act           = !rst_in;
    assign cpu_vram_hit  = cpu_addr_in[15:13] == 3'b100;
    assign cpu_oam_hit   = cpu_addr_in[15:8] == 8'hFE && cpu_addr_in[7:0] < 8'hA0;
    assign cpu_void_hit  = cpu_addr_in[15:8] == 8'hFE && cpu_addr_in[7:0] >= 8'hA0;
    assign cpu_dma_hit   = cpu_addr_in == 16'hFF46;
    assign ppu_owns_vram = lcd_en_in && ppu_mode_in == 2'd3;
    assign ppu_owns_oam  = lcd_en_in && ppu_mode_in[1];
    assign cpu_owns_oam  = !dma_active_out && !ppu_owns_oam;
    assign dma_restart   = act && cpu_req_in && cpu_we_in && cpu_dma_hit;
    assign dma_wr        = act && pend_q && dma_src_valid_in && !dma_restart;
    assign ppu_vram_go   = act && ppu_vram_req_in && ppu_owns_vram;
    assign ppu_oam_go    = act && ppu_oam_req_in && ppu_owns_oam && !dma_wr;
    assign cpu_vram_go   = act && cpu_req_in && cpu_vram_hit && !ppu_owns_vram;
    assign cpu_oam_go    = act && cpu_req_in && cpu_oam_hit && cpu_owns_oam;

    always_comb begin
        rsp_d = RSP_NONE;
        if (act && cpu_req_in) begin
            unique case (1'b1)
                cpu_vram_hit: rsp_d = cpu_we_in ? RSP_ZERO :
                                      (ppu_owns_vram ? RSP_FF : RSP_VRAM);
                cpu_oam_hit:  rsp_d = cpu_we_in ? RSP_ZERO :
                                      (cpu_owns_oam ? RSP_OAM : RSP_FF);
                cpu_void_hit: rsp_d = RSP_ZERO;
                cpu_dma_hit:  rsp_d = cpu_we_in ? RSP_ZERO : RSP_REG;
                default:      rsp_d = RSP_NONE;
            endcase
        end
    end

    always_comb begin
        vram_addr_out  = 13'h0;
        vram_we_out    = 1'b0;
        vram_wdata_out = 8'h00;
        if (ppu_vram_go) begin
            vram_addr_out = ppu_vram_addr_in;
        end else if (cpu_vram_go) begin
            vram_addr_out  = cpu_addr_in[12:0];
            vram_we_out    = cpu_we_in;
            vram_wdata_out = cpu_we_in ? cpu_wdata_in : 8'h00;
        end
    end

    always_comb begin
        oam_addr_out  = 8'h00;
        oam_we_out    = 1'b0;
        oam_wdata_out = 8'h00;
        if (dma_wr) begin
            oam_addr_out  = idx_q;
            oam_we_out    = 1'b1;
            oam_wdata_out = dma_src_data_in;
        end else if (ppu_oam_go) begin
            oam_addr_out = ppu_oam_addr_in;
        end else if (cpu_oam_go) begin
            oam_addr_out  = cpu_addr_in[7:0];
            oam_we_out    = cpu_we_in;
            oam_wdata_out = cpu_we_in ? cpu_wdata_in : 8'h00;
        end
    end

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        req_d    = 1'b0;
        shadow_d = shadow_q;
        src_hi_d = src_hi_q;
        unique case (state_q)
            DMA_IDLE: ;
            DMA_START: begin
                if (tick_in) begin
                    if (tcnt_q == START_LAST) begin
                        state_d = DMA_XFER;
                        tcnt_d  = 8'h00;
                        req_d   = 1'b1;
                        pend_d  = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            DMA_XFER: begin
                if (dma_wr) begin
                    pend_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DMA_IDLE;
                        idx_d   = 8'h00;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                // A byte slot with its request still outstanding is skipped
                if (tick_in) begin
                    if (tcnt_q == BYTE_LAST) begin
                        tcnt_d = 8'h00;
                        if (!pend_q) begin
                            req_d  = 1'b1;
                            pend_d = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = DMA_IDLE;
        endcase
        if (dma_restart) begin
            shadow_d = cpu_wdata_in;
            src_hi_d = cpu_wdata_in >= 8'hE0 ? (cpu_wdata_in & 8'hDF) : cpu_wdata_in;
            state_d  = DMA_START;
            tcnt_d   = 8'h00;
            idx_d    = 8'h00;
            pend_d   = 1'b0;
            req_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= DMA_IDLE;
            rsp_q    <= RSP_NONE;
            tcnt_q   <= 8'h00;
            idx_q    <= 8'h00;
            shadow_q <= 8'h00;
            src_hi_q <= 8'h00;
            pend_q   <= 1'b0;
            req_q    <= 1'b0;
            pvv_q    <= 1'b0;
            pov_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rsp_q    <= rsp_d;
            tcnt_q   <= tcnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            src_hi_q <= src_hi_d;
            pend_q   <= pend_d;
            req_q    <= req_d;
            pvv_q    <= ppu_vram_go;
            pov_q    <= ppu_oam_go;
        end
    end

    always_comb begin
        unique case (rsp_q)
            RSP_VRAM: cpu_rdata_out = vram_rdata_in;
            RSP_OAM:  cpu_rdata_out = oam_rdata_in;
            RSP_FF:   cpu_rdata_out = 8'hFF;
            RSP_REG:  cpu_rdata_out = shadow_q;
            default:  cpu_rdata_out = 8'h00;
        endcase
    end

    assign cpu_ack_out        = rsp_q != RSP_NONE;
    assign ppu_vram_valid_out = pvv_q;
    assign ppu_vram_data_out  = pvv_q ? vram_rdata_in : 8'h00;
    assign ppu_oam_valid_out  = pov_q;
    assign ppu_oam_data_out   = pov_q ? oam_rdata_in : 8'h00;
    assign dma_src_req_out    = req_q;
    assign dma_src_addr_out   = {src_hi_q, idx_q};
    assign dma_active_out     = state_q != DMA_IDLE;

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Randomized bench for ppu_mem_arbiter with block-RAM, DMA-source and
// ownership reference models.
module tb_ppu_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        tick_in = 1'b1;
    logic        lcd_en_in = 1'b0;
    logic [1:0]  ppu_mode_in = 2'd0;
    logic        cpu_req_in = 1'b0;
    logic [15:0] cpu_addr_in = 16'h0;
    logic        cpu_we_in = 1'b0;
    logic [7:0]  cpu_wdata_in = 8'h0;
    logic [7:0]  cpu_rdata_out;
    logic        cpu_ack_out;
    logic        ppu_vram_req_in = 1'b0;
    logic [12:0] ppu_vram_addr_in = 13'h0;
    logic [7:0]  ppu_vram_data_out;
    logic        ppu_vram_valid_out;
    logic        ppu_oam_req_in = 1'b0;
    logic [7:0]  ppu_oam_addr_in = 8'h0;
    logic [7:0]  ppu_oam_data_out;
    logic        ppu_oam_valid_out;
    logic [12:0] vram_addr_out;
    logic        vram_we_out;
    logic [7:0]  vram_wdata_out;
    logic [7:0]  vram_rdata_in;
    logic [7:0]  oam_addr_out;
    logic        oam_we_out;
    logic [7:0]  oam_wdata_out;
    logic [7:0]  oam_rdata_in;
    logic        dma_src_req_out;
    logic [15:0] dma_src_addr_out;
    logic [7:0]  dma_src_data_in = 8'h0;
    logic        dma_src_valid_in = 1'b0;
    logic        dma_active_out;

    int tests = 0;
    int fails = 0;

    logic [7:0] vram_env [8192];
    logic [7:0] oam_env  [256];
    logic [7:0] exp_vram [8192];
    logic [7:0] exp_oam  [256];
    logic [7:0] shadow_m = 8'h00;
    logic [7:0] dma_hi = 8'h00;
    bit load = 1'b0;
    bit src_en = 1'b1;
    bit stray = 1'b0;
    bit tick_rand = 1'b0;

    ppu_mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .tick_in(tick_in),
        .lcd_en_in(lcd_en_in), .ppu_mode_in(ppu_mode_in),
        .cpu_req_in(cpu_req_in), .cpu_addr_in(cpu_addr_in),
        .cpu_we_in(cpu_we_in), .cpu_wdata_in(cpu_wdata_in),
        .cpu_rdata_out(cpu_rdata_out), .cpu_ack_out(cpu_ack_out),
        .ppu_vram_req_in(ppu_vram_req_in), .ppu_vram_addr_in(ppu_vram_addr_in),
        .ppu_vram_data_out(ppu_vram_data_out), .ppu_vram_valid_out(ppu_vram_valid_out),
        .ppu_oam_req_in(ppu_oam_req_in), .ppu_oam_addr_in(ppu_oam_addr_in),
        .ppu_oam_data_out(ppu_oam_data_out), .ppu_oam_valid_out(ppu_oam_valid_out),
        .vram_addr_out(vram_addr_out), .vram_we_out(vram_we_out),
        .vram_wdata_out(vram_wdata_out), .vram_rdata_in(vram_rdata_in),
        .oam_addr_out(oam_addr_out), .oam_we_out(oam_we_out),
        .oam_wdata_out(oam_wdata_out), .oam_rdata_in(oam_rdata_in),
        .dma_src_req_out(dma_src_req_out), .dma_src_addr_out(dma_src_addr_out),
        .dma_src_data_in(dma_src_data_in), .dma_src_valid_in(dma_src_valid_in),
        .dma_active_out(dma_active_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] srcb(input logic [15:0] a);
        return a[7:0] + a[15:8] + 8'h3F;
    endfunction

    // Synchronous-read block RAMs
    always @(posedge clk_in) begin
        if (load) begin
            for (int i = 0; i < 8192; i++) vram_env[i] <= exp_vram[i];
            for (int i = 0; i < 256; i++) oam_env[i] <= exp_oam[i];
        end else begin
            if (vram_we_out) vram_env[vram_addr_out] <= vram_wdata_out;
            if (oam_we_out) oam_env[oam_addr_out] <= oam_wdata_out;
        end
        vram_rdata_in <= vram_env[vram_addr_out];
        oam_rdata_in  <= oam_env[oam_addr_out];
    end

    // Main-bus source answers during the request cycle; tick strobe source
    always @(posedge clk_in) begin
        #2;
        dma_src_valid_in = (dma_src_req_out && src_en) || stray;
        dma_src_data_in  = srcb(dma_src_addr_out);
        tick_in = tick_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit creq, input logic [15:0] a, input bit we,
                        input logic [7:0] wd, input bit vreq, input logic [12:0] va,
                        input bit oreq, input logic [7:0] oa);
        bit pv, po, vv, ov, cv, eack, vwe, owe;
        logic [7:0] erd, vd, od;
        @(negedge clk_in);
        cpu_req_in = creq; cpu_addr_in = a; cpu_we_in = we; cpu_wdata_in = wd;
        ppu_vram_req_in = vreq; ppu_vram_addr_in = va;
        ppu_oam_req_in = oreq; ppu_oam_addr_in = oa;
        pv = lcd_en_in && ppu_mode_in == 2'd3;
        po = lcd_en_in && ppu_mode_in >= 2'd2;
        vv = vreq && pv;
        ov = oreq && po;
        vd = exp_vram[va];
        od = exp_oam[oa];
        eack = 0; erd = 8'h00; vwe = 0; owe = 0; cv = 0;
        if (creq) begin
            if (a >= 16'h8000 && a <= 16'h9FFF) begin
                eack = 1; cv = !pv;
                if (pv) erd = 8'hFF;
                else if (we) begin vwe = 1; exp_vram[a[12:0]] = wd; end
                else erd = exp_vram[a[12:0]];
            end else if (a >= 16'hFE00 && a <= 16'hFE9F) begin
                eack = 1;
                if (po) erd = 8'hFF;
                else if (we) begin owe = 1; exp_oam[a[7:0]] = wd; end
                else erd = exp_oam[a[7:0]];
            end else if (a >= 16'hFEA0 && a <= 16'hFEFF) begin
                eack = 1;
            end else if (a == 16'hFF46) begin
                eack = 1; erd = shadow_m;
            end
        end
        #1;
        chk("vram_we", 16'(vram_we_out), 16'(vwe));
        chk("oam_we", 16'(oam_we_out), 16'(owe));
        if (vv) chk("vram_addr_ppu", 16'(vram_addr_out), 16'(va));
        if (cv) chk("vram_addr_cpu", 16'(vram_addr_out), 16'(a[12:0]));
        if (vwe) chk("vram_wdata", 16'(vram_wdata_out), 16'(wd));
        if (owe) chk("oam_wdata", 16'(oam_wdata_out), 16'(wd));
        @(posedge clk_in);
        #1;
        chk("cpu_ack", 16'(cpu_ack_out), 16'(eack));
        if (eack && !we) chk("cpu_rdata", 16'(cpu_rdata_out), 16'(erd));
        chk("ppu_vram_valid", 16'(ppu_vram_valid_out), 16'(vv));
        if (vv) chk("ppu_vram_data", 16'(ppu_vram_data_out), 16'(vd));
        chk("ppu_oam_valid", 16'(ppu_oam_valid_out), 16'(ov));
        if (ov) chk("ppu_oam_data", 16'(ppu_oam_data_out), 16'(od));
    endtask

    task automatic start_dma(input logic [7:0] v);
        @(negedge clk_in);
        cpu_req_in = 1'b1; cpu_addr_in = 16'hFF46; cpu_we_in = 1'b1; cpu_wdata_in = v;
        ppu_vram_req_in = 1'b0; ppu_oam_req_in = 1'b0;
        shadow_m = v;
        dma_hi = v >= 8'hE0 ? (v & 8'hDF) : v;
        @(posedge clk_in);
        #1;
        chk("ff46_ack", 16'(cpu_ack_out), 16'd1);
    endtask

    task automatic watch(input int max_bytes, input bit cpu_probe, input bit ppu_probe);
        int nwr = 0, ticks = 0, cyc = 0;
        bit first = 1, act_ok = 1, prev_o = 0, prev_v = 0;
        logic [7:0] prev_d = 8'h00;
        logic [15:0] sa;
        while (cyc < 4000 && nwr < max_bytes) begin
            @(negedge clk_in);
            cpu_req_in = 1'b0; cpu_we_in = 1'b0;
            if (prev_o) begin
                chk("dma_ppu_oam_valid", 16'(ppu_oam_valid_out), 16'(prev_v));
                if (prev_v) chk("dma_ppu_oam_data", 16'(ppu_oam_data_out), 16'(prev_d));
            end
            if (cpu_probe && cyc == 41) begin
                chk("dma_cpu_ack", 16'(cpu_ack_out), 16'd1);
                chk("dma_cpu_rdata", 16'(cpu_rdata_out), 16'h00FF);
            end
            if (cpu_probe && cyc == 40) begin
                cpu_req_in = 1'b1; cpu_addr_in = 16'hFE05;
            end
            if (!dma_active_out) act_ok = 0;
            if (dma_src_req_out) begin
                if (first) chk("dma_start_ticks", 16'(ticks), 16'd4);
                first = 0;
                chk("dma_src_addr", dma_src_addr_out, {dma_hi, nwr[7:0]});
            end
            prev_o = ppu_probe;
            prev_v = !oam_we_out;
            if (ppu_probe) begin
                ppu_oam_req_in = 1'b1;
                ppu_oam_addr_in = 8'($urandom_range(0, 159));
                prev_d = exp_oam[ppu_oam_addr_in];
            end
            if (oam_we_out) begin
                sa = {dma_hi, nwr[7:0]};
                chk("dma_oam_addr", 16'(oam_addr_out), 16'(nwr));
                chk("dma_oam_data", 16'(oam_wdata_out), 16'(srcb(sa)));
                exp_oam[nwr] = srcb(sa);
                nwr++;
            end
            if (tick_in) ticks++;
            cyc++;
        end
        ppu_oam_req_in = 1'b0;
        chk("dma_timeout", 16'(nwr), 16'(max_bytes));
        chk("dma_active_held", 16'(act_ok), 16'd1);
    endtask

    task automatic cmp_oam(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (oam_env[i] !== exp_oam[i]) bad++;
        chk(tag, 16'(bad), 16'd0);
    endtask

    initial begin
        int r, cnt;
        logic [15:0] a;
        bit we;
        for (int i = 0; i < 8192; i++) exp_vram[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) exp_oam[i] = 8'($urandom);
        exp_vram[0] = 8'h5A;
        load = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        load = 1'b0;
        chk("rst_ack", 16'(cpu_ack_out), 16'd0);
        chk("rst_rdata", 16'(cpu_rdata_out), 16'd0);
        chk("rst_dma_active", 16'(dma_active_out), 16'd0);
        chk("rst_src_req", 16'(dma_src_req_out), 16'd0);
        chk("rst_src_addr", dma_src_addr_out, 16'd0);
        chk("rst_valids", 16'({ppu_vram_valid_out, ppu_oam_valid_out}), 16'd0);
        chk("rst_we", 16'({vram_we_out, oam_we_out}), 16'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        lcd_en_in = 1'b1; ppu_mode_in = 2'd3;
        step(1'b1, 16'h8000, 1'b0, 8'h00, 1'b0, 13'h0, 1'b0, 8'h00);
        ppu_mode_in = 2'd0;
        step(1'b1, 16'h8000, 1'b0, 8'h00, 1'b0, 13'h0, 1'b0, 8'h00);
        ppu_mode_in = 2'd2;
        step(1'b1, 16'hFE10, 1'b1, 8'h33, 1'b0, 13'h0, 1'b0, 8'h00);
        ppu_mode_in = 2'd1;
        step(1'b1, 16'hFE10, 1'b0, 8'h00, 1'b0, 13'h0, 1'b0, 8'h00);
        step(1'b1, 16'hFE10, 1'b1, 8'h33, 1'b0, 13'h0, 1'b0, 8'h00);
        step(1'b1, 16'hFE10, 1'b0, 8'h00, 1'b0, 13'h0, 1'b0, 8'h00);
        ppu_mode_in = 2'd3;
        step(1'b1, 16'h8123, 1'b1, 8'h99, 1'b1, 13'h0010, 1'b0, 8'h00);
        ppu_mode_in = 2'd2;
        step(1'b1, 16'hFE20, 1'b1, 8'h77, 1'b0, 13'h0, 1'b1, 8'h20);
        lcd_en_in = 1'b0; ppu_mode_in = 2'd3;
        step(1'b1, 16'h8010, 1'b0, 8'h00, 1'b1, 13'h0010, 1'b1, 8'h10);
        step(1'b1, 16'hFF46, 1'b0, 8'h00, 1'b0, 13'h0, 1'b0, 8'h00);
        step(1'b1, 16'hFEC0, 1'b0, 8'h00, 1'b0, 13'h0, 1'b0, 8'h00);
        step(1'b1, 16'hC000, 1'b0, 8'h00, 1'b0, 13'h0, 1'b0, 8'h00);

        repeat (400) begin
            lcd_en_in = 1'($urandom_range(0, 1));
            ppu_mode_in = 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 5));
            case (r)
                0, 1: a = 16'h8000 | 16'($urandom_range(0, 8191));
                2: a = 16'hFE00 + 16'($urandom_range(0, 159));
                3: a = 16'hFEA0 + 16'($urandom_range(0, 95));
                4: a = 16'hFF46;
                default: a = 16'hC000 + 16'($urandom_range(0, 4095));
            endcase
            we = (r != 4) && ($urandom_range(0, 1) == 1);
            step(1'($urandom_range(0, 1)), a, we, 8'($urandom),
                 1'($urandom_range(0, 1)), 13'($urandom),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 159)));
        end
        step(1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 13'h0, 1'b0, 8'h00);

        lcd_en_in = 1'b1; ppu_mode_in = 2'd0;
        stray = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk_in);
            if (oam_we_out) cnt++;
        end
        stray = 1'b0;
        chk("stray_valid_we", 16'(cnt), 16'd0);

        start_dma(8'hC1);
        watch(160, 1'b1, 1'b0);
        @(posedge clk_in);
        #1;
        chk("dma_done", 16'(dma_active_out), 16'd0);
        cmp_oam("oam_after_c1");
        chk("oam_c1_0", 16'(oam_env[0]), 16'h0000);
        chk("oam_c1_100", 16'(oam_env[100]), 16'd100);
        chk("oam_c1_159", 16'(oam_env[159]), 16'd159);
        step(1'b1, 16'hFF46, 1'b0, 8'h00, 1'b0, 13'h0, 1'b0, 8'h00);

        start_dma(8'hC1);
        watch(50, 1'b0, 1'b0);
        ppu_mode_in = 2'd2;
        tick_rand = 1'b1;
        start_dma(8'hD0);
        watch(160, 1'b0, 1'b1);
        @(posedge clk_in);
        #1;
        chk("dma_done_d0", 16'(dma_active_out), 16'd0);
        cmp_oam("oam_after_d0");

        tick_rand = 1'b0;
        ppu_mode_in = 2'd0;
        start_dma(8'hF0);
        chk("dma_hi_f0", 16'(dma_hi), 16'h00D0);
        watch(3, 1'b0, 1'b0);
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        chk("async_rst_active", 16'(dma_active_out), 16'd0);
        chk("async_rst_src_req", 16'(dma_src_req_out), 16'd0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        shadow_m = 8'h00;
        cnt = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (oam_we_out || dma_src_req_out) cnt++;
        end
        chk("post_rst_quiet", 16'(cnt), 16'd0);
        step(1'b1, 16'hFF46, 1'b0, 8'h00, 1'b0, 13'h0, 1'b0, 8'h00);
        step(1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 13'h0, 1'b0, 8'h00);
        cmp_oam("oam_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
